// File: rtl/clock_set_ctrl.sv
// Front-panel key controller for the time-of-day counter: debounces MODE/UP/DOWN,
// steps through the set modes, auto-repeats held keys and drops back to run when idle.
module clock_set_ctrl #(
  parameter int DEBOUNCE_TICKS = 2,
  parameter int REPEAT_DELAY   = 50,
  parameter int REPEAT_RATE    = 10,
  parameter int TIMEOUT        = 1000,
  parameter int BLINK_HALF     = 25
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       KEY_MODE,
  input  logic       KEY_UP,
  input  logic       KEY_DWN,
  output logic [1:0] FLAG,
  output logic       UP,
  output logic       DWN,
  output logic       EDIT,
  output logic       BLINK
);

  // state | meaning
  // RUN   | clock running, UP/DOWN keys ignored
  // SET_H | adjusting hours
  // SET_M | adjusting minutes
  // SET_S | adjusting seconds
  typedef enum logic [1:0] {
    RUN   = 2'b00,
    SET_H = 2'b01,
    SET_M = 2'b10,
    SET_S = 2'b11
  } flag_t;

  localparam int DW   = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS) : 1;
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = (RMAX > 1) ? $clog2(RMAX) : 1;
  localparam int TW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int BW   = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

  // key index: 0 = MODE, 1 = UP, 2 = DOWN
  logic [2:0]    raw, sync1, sync2, lvl, lvl_d, press;
  logic [DW-1:0] db_cnt [3];

  flag_t         flag_q, flag_nxt;
  logic          in_set, both, flag_chg, activity, tmo_hit;
  logic [1:0]    req, hold_on;
  logic [RW-1:0] hold_cnt [2];
  logic [TW-1:0] tmo_cnt;
  logic [BW-1:0] blink_cnt;
  logic          blink_q, up_q, dwn_q;

  assign raw    = {KEY_DWN, KEY_UP, KEY_MODE};
  assign press  = lvl & ~lvl_d;
  assign in_set = (flag_q != RUN);
  assign both   = lvl[1] & lvl[2];

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      sync1 <= '0;
      sync2 <= '0;
      lvl   <= '0;
      lvl_d <= '0;
      for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      lvl_d <= lvl;
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] == lvl[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DW'(DEBOUNCE_TICKS - 1)) begin
          lvl[i]    <= ~lvl[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  // A MODE press takes the cycle: any UP/DOWN event alongside it is dropped.
  always_comb begin
    flag_nxt = flag_q;
    req      = 2'b00;
    activity = 1'b0;
    tmo_hit  = 1'b0;
    flag_chg = 1'b0;
    if (in_set && !press[0] && !both) begin
      req[0] = lvl[1] & (press[1] | (hold_on[0] & (hold_cnt[0] == '0)));
      req[1] = lvl[2] & (press[2] | (hold_on[1] & (hold_cnt[1] == '0)));
    end
    activity = (|press) | (|req);
    tmo_hit  = in_set & ~activity & (tmo_cnt == '0);
    if (press[0]) begin
      case (flag_q)
        RUN:     flag_nxt = SET_H;
        SET_H:   flag_nxt = SET_M;
        SET_M:   flag_nxt = SET_S;
        default: flag_nxt = RUN;
      endcase
    end else if (tmo_hit) begin
      flag_nxt = RUN;
    end
    flag_chg = (flag_nxt != flag_q);
  end

  always_ff @(posedge CLK) begin
    if (!RESET) flag_q <= RUN;
    else        flag_q <= flag_nxt;
  end

  // Hold timers only arm on a press pulse, so a key that lost its hold stays quiet until re-pressed.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      hold_on <= '0;
      for (int j = 0; j < 2; j++) hold_cnt[j] <= '0;
    end else begin
      for (int j = 0; j < 2; j++) begin
        if (flag_chg || !lvl[j+1] || both) begin
          hold_on[j] <= 1'b0;
        end else if (req[j] && press[j+1]) begin
          hold_on[j]  <= 1'b1;
          hold_cnt[j] <= RW'(REPEAT_DELAY - 1);
        end else if (req[j]) begin
          hold_cnt[j] <= RW'(REPEAT_RATE - 1);
        end else if (hold_on[j]) begin
          hold_cnt[j] <= hold_cnt[j] - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      tmo_cnt <= '0;
    end else if (flag_chg || (in_set && activity)) begin
      tmo_cnt <= TW'(TIMEOUT - 1);
    end else if (in_set) begin
      tmo_cnt <= tmo_cnt - 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      blink_q   <= 1'b1;
      blink_cnt <= '0;
    end else if (flag_chg || (|req)) begin
      blink_q   <= 1'b1;
      blink_cnt <= BW'(BLINK_HALF - 1);
    end else if (!in_set) begin
      blink_q <= 1'b1;
    end else if (blink_cnt == '0) begin
      blink_q   <= ~blink_q;
      blink_cnt <= BW'(BLINK_HALF - 1);
    end else begin
      blink_cnt <= blink_cnt - 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      up_q  <= 1'b0;
      dwn_q <= 1'b0;
    end else begin
      up_q  <= req[0];
      dwn_q <= req[1];
    end
  end

  assign FLAG  = flag_q;
  assign UP    = up_q;
  assign DWN   = dwn_q;
  assign EDIT  = (flag_q != RUN);
  assign BLINK = blink_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Bench for clock_set_ctrl: event-time reference model checked every cycle,
// directed scenarios with hand-computed timings, then randomized key activity.
module tb_clock_set_ctrl;

  localparam int DB = 2;
  localparam int RD = 50;
  localparam int RR = 10;
  localparam int TO = 1000;
  localparam int BH = 25;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       key_mode = 1'b0, key_up = 1'b0, key_dwn = 1'b0;
  logic [1:0] FLAG;
  logic       UP, DWN, EDIT, BLINK;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  clock_set_ctrl #(
    .DEBOUNCE_TICKS(DB), .REPEAT_DELAY(RD), .REPEAT_RATE(RR),
    .TIMEOUT(TO), .BLINK_HALF(BH)
  ) dut (
    .CLK(clk), .RESET(rst), .KEY_MODE(key_mode), .KEY_UP(key_up), .KEY_DWN(key_dwn),
    .FLAG(FLAG), .UP(UP), .DWN(DWN), .EDIT(EDIT), .BLINK(BLINK)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // Reference model: keys as debounced levels, repeats and timeout as absolute edge times.
  bit         m_valid = 0;
  logic [1:0] m_flag = 2'd0;
  bit         m_up, m_dwn, m_blink = 1;
  bit         lvl[3], rose[3], s1[3], s2[3], armed[2];
  int         run_len[3];
  int         next_rep[2];
  int         last_clear, blink_start;

  always @(posedge clk) begin
    bit raw[3];
    bit mp, pls[2], act, tmo;
    logic [1:0] nf;
    cyc++;
    raw[0] = key_mode; raw[1] = key_up; raw[2] = key_dwn;
    if (!rst) begin
      m_valid = 1;
      for (int i = 0; i < 3; i++) begin
        lvl[i] = 0; rose[i] = 0; s1[i] = 0; s2[i] = 0; run_len[i] = 0;
      end
      armed[0] = 0; armed[1] = 0;
      m_flag = 2'd0; m_up = 0; m_dwn = 0; m_blink = 1;
      last_clear = cyc; blink_start = cyc;
    end else begin
      mp = rose[0];
      for (int j = 0; j < 2; j++)
        pls[j] = (m_flag != 2'd0) && !mp && lvl[j+1] && !(lvl[1] && lvl[2]) &&
                 (rose[j+1] || (armed[j] && cyc == next_rep[j]));
      act = rose[0] || rose[1] || rose[2] || pls[0] || pls[1];
      tmo = (m_flag != 2'd0) && !act && (cyc - last_clear == TO);
      nf  = mp ? m_flag + 2'd1 : (tmo ? 2'd0 : m_flag);
      for (int j = 0; j < 2; j++) begin
        if (nf != m_flag || !lvl[j+1] || (lvl[1] && lvl[2])) armed[j] = 0;
        else if (pls[j] && rose[j+1]) begin armed[j] = 1; next_rep[j] = cyc + RD; end
        else if (pls[j]) next_rep[j] = cyc + RR;
      end
      if (nf != m_flag || act) last_clear = cyc;
      if (nf != m_flag || pls[0] || pls[1]) blink_start = cyc;
      m_blink = (nf == 2'd0) ? 1 : (((cyc - blink_start) / BH) % 2 == 0);
      m_flag = nf; m_up = pls[0]; m_dwn = pls[1];
      for (int i = 0; i < 3; i++) begin
        rose[i] = 0;
        if (s2[i] != lvl[i]) begin
          run_len[i]++;
          if (run_len[i] == DB) begin lvl[i] = !lvl[i]; run_len[i] = 0; rose[i] = lvl[i]; end
        end else run_len[i] = 0;
        s2[i] = s1[i]; s1[i] = raw[i];
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      tests++;
      if ({FLAG, UP, DWN, EDIT, BLINK} !== {m_flag, m_up, m_dwn, m_flag != 2'd0, m_blink}) begin
        fails++;
        $display("FAIL cycle_cmp @%0d: got FLAG=%b UP=%b DWN=%b EDIT=%b BLINK=%b, expected FLAG=%b UP=%b DWN=%b EDIT=%b BLINK=%b",
                 cyc, FLAG, UP, DWN, EDIT, BLINK, m_flag, m_up, m_dwn, m_flag != 2'd0, m_blink);
      end
    end
  end

  int         up_times[$], dwn_times[$];
  logic [1:0] up_flags[$];
  always @(negedge clk) begin
    if (UP === 1'b1) begin up_times.push_back(cyc); up_flags.push_back(FLAG); end
    if (DWN === 1'b1) dwn_times.push_back(cyc);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @%0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic clear_q();
    up_times.delete(); up_flags.delete(); dwn_times.delete();
  endtask

  task automatic mode_step(input logic [1:0] expf, output int k);
    logic [1:0] prev;
    prev = expf - 2'd1;
    key_mode = 1'b1;
    k = cyc + 1;
    wait_cyc(k + 3);
    check("mode_before", FLAG, prev);
    wait_cyc(k + 4);
    check("mode_after", FLAG, expf);
    check("mode_edit", EDIT, expf != 2'd0);
    wait_cyc(k + 9);
    key_mode = 1'b0;
    tick(10);
  endtask

  initial begin
    int k, e;
    int exp_rep[4];
    exp_rep[0] = 0; exp_rep[1] = RD; exp_rep[2] = RD + RR; exp_rep[3] = RD + 2 * RR;

    tick(3);
    check("reset_flag", FLAG, 0);
    check("reset_blink", BLINK, 1);
    check("reset_up_dwn", {UP, DWN, EDIT}, 0);
    rst = 1'b1;
    tick(5);

    mode_step(2'd1, k); mode_step(2'd2, k); mode_step(2'd3, k); mode_step(2'd0, k);

    // glitch then real UP press in SET_H
    mode_step(2'd1, k);
    clear_q();
    key_up = 1'b1; tick(1); key_up = 1'b0; tick(10);
    check("glitch_no_pulse", up_times.size(), 0);
    key_up = 1'b1; k = cyc + 1; tick(5); key_up = 1'b0; tick(10);
    check("tap_pulse_count", up_times.size(), 1);
    if (up_times.size() > 0) begin
      check("tap_latency", up_times[0] - k, 4);
      check("tap_flag", up_flags[0], 1);
    end

    // DOWN held 80 ticks in SET_M
    mode_step(2'd2, k);
    clear_q();
    key_dwn = 1'b1; k = cyc + 1; tick(80); key_dwn = 1'b0; tick(20);
    check("repeat_count", dwn_times.size(), 4);
    check("repeat_no_up", up_times.size(), 0);
    if (dwn_times.size() > 0) check("repeat_latency", dwn_times[0] - k, 4);
    for (int i = 0; i < dwn_times.size() && i < 4; i++)
      check("repeat_time", dwn_times[i] - dwn_times[0], exp_rep[i]);

    // UP held, DOWN joins, DOWN released, UP re-pressed in SET_S
    mode_step(2'd3, k);
    clear_q();
    key_up = 1'b1; k = cyc + 1;
    wait_cyc(k + 56); key_dwn = 1'b1;
    tick(30); key_dwn = 1'b0;
    tick(30); key_up = 1'b0; tick(10);
    check("both_up_count", up_times.size(), 2);
    check("both_dwn_count", dwn_times.size(), 0);
    if (up_times.size() > 1) check("both_second_pulse", up_times[1] - k, 4 + RD);
    key_up = 1'b1; tick(5); key_up = 1'b0; tick(10);
    check("repress_count", up_times.size(), 3);

    // idle timeout
    mode_step(2'd0, k);
    mode_step(2'd1, k);
    e = k + 4;
    wait_cyc(e + BH - 1); check("blink_on", BLINK, 1);
    wait_cyc(e + BH);     check("blink_off", BLINK, 0);
    wait_cyc(e + TO - 1); check("timeout_before", FLAG, 1);
    wait_cyc(e + TO);     check("timeout_flag", FLAG, 0); check("timeout_blink", BLINK, 1);
    tick(5);

    // timeout pushed out by an UP pulse at tick 900
    mode_step(2'd1, k);
    e = k + 4;
    clear_q();
    wait_cyc(e + 895); key_up = 1'b1; tick(5); key_up = 1'b0;
    wait_cyc(e + TO); check("pushed_still_set", FLAG, 1);
    check("pushed_pulse_count", up_times.size(), 1);
    if (up_times.size() > 0) check("pushed_pulse_time", up_times[0] - e, 900);
    wait_cyc(e + 900 + TO - 1); check("pushed_before", FLAG, 1);
    wait_cyc(e + 900 + TO);     check("pushed_timeout", FLAG, 0);
    tick(5);

    // MODE and UP together in SET_H
    mode_step(2'd1, k);
    clear_q();
    key_mode = 1'b1; key_up = 1'b1; k = cyc + 1;
    wait_cyc(k + 3); check("mode_up_before", FLAG, 1);
    wait_cyc(k + 4); check("mode_up_after", FLAG, 2);
    wait_cyc(k + 19); key_mode = 1'b0; key_up = 1'b0; tick(10);
    check("mode_up_no_pulse", up_times.size(), 0);

    // reset during UP hold in SET_S, landing on a repeat edge
    mode_step(2'd3, k);
    clear_q();
    key_up = 1'b1; k = cyc + 1;
    wait_cyc(k + 4 + RD - 1); rst = 1'b0;
    wait_cyc(k + 4 + RD);
    check("rst_flag", FLAG, 0);
    check("rst_up", UP, 0);
    tick(1); rst = 1'b1;
    tick(20); key_up = 1'b0; tick(10);
    check("rst_pulse_count", up_times.size(), 1);

    // randomized key activity
    for (int it = 0; it < 300; it++) begin
      if ($urandom_range(0, 99) < 2) begin rst = 1'b0; tick(2); rst = 1'b1; end
      key_mode = ($urandom_range(0, 5) == 0);
      key_up   = $urandom_range(0, 1);
      key_dwn  = ($urandom_range(0, 2) == 0);
      tick($urandom_range(1, 70));
      if ($urandom_range(0, 3) == 0) begin key_dwn = ~key_dwn; tick($urandom_range(1, 30)); end
      key_mode = 1'b0; key_up = 1'b0; key_dwn = 1'b0;
      if ($urandom_range(0, 39) == 0) tick(TO + 5);
      else tick($urandom_range(0, 12));
    end
    tick(20);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
